vga_image_display: RTL
======================

# vga_image_display

Downstream display stage for the decrypted image buffer. Generates 640x480@60 Hz VGA timing, fetches the 175x175 8-bit image from the frame buffer written by the decryption stage, centres it on screen and drives RGB332 plus active-low syncs. Blanks the picture until decryption is complete, switching only on frame boundaries so no partial image is shown.

## Interface

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (50 MHz clk -> 25 MHz pixel rate)
- IMG_W, 175, source image width in pixels
- IMG_H, 175, source image height in pixels

Ports:
- clk  input  1  system clock; one clock, all logic on posedge
- reset  input  1  synchronous, active-high reset
- decrypt_done  input  1  level; frame buffer fully written
- pixel_data  input  8  frame-buffer read data, RGB332 {r[2:0],g[2:0],b[1:0]}; valid 1 clk after read_addr
- read_addr  output  15  frame-buffer read address, row-major, 0..IMG_W*IMG_H-1
- hsync  output  1  active-low horizontal sync
- vsync  output  1  active-low vertical sync
- red  output  3  pixel red
- green  output  3  pixel green
- blue  output  2  pixel blue
- frame_start  output  1  one-clk pulse on the tick where hc=0, vc=0

## Operation

- Tick divider: counts 0..CLK_DIV-1; tick asserted when divider = CLK_DIV-1. All state below updates only on tick, except frame_start (single clk wide).
- hc 0..799: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799; wraps to 0 and increments vc.
- vc 0..524: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524; wraps to 0.
- Displayed size DW=IMG_W, DH=IMG_H; offsets X0=(640-DW)/2, Y0=(480-DH)/2, integer floor (232, 152 at defaults).
- in_img = X0<=hc<X0+DW and Y0<=vc<Y0+DH.
- Address generated incrementally, no multiplier: col and row_base registers. col resets at each line start; increments each in_img tick. row_base = 0 at frame start; += IMG_W after last in_img pixel of an image line. read_addr <= row_base + col on in_img ticks; holds otherwise.
- show_img sampled from decrypt_done at frame start only; held for the whole frame. decrypt_done changes mid-frame take effect next frame.
- Output stage (one tick after address): {red,green,blue} <= (in_img_d & show_img) ? pixel_data : 0; hsync/vsync delayed one tick from the counters so syncs, colour and counters stay aligned.
- Arithmetic: hc/vc 10 bits; read_addr 15 bits, never exceeds IMG_W*IMG_H-1 (30624); no wrap within a frame.

## Timing

- Reset values: read_addr=0, hsync=1, vsync=1, red/green/blue=0, frame_start=0, hc=vc=0, divider=0, show_img=0.
- Reset mid-frame: all of the above restored next clk; a fresh frame begins at hc=0, vc=0 with show_img re-sampled.
- Pipeline latency: counter position (hc,vc) appears on outputs exactly 1 tick (CLK_DIV clks) later; frame-buffer data needs 1 clk, so CLK_DIV>=2 is required.
- hsync low for 96 ticks per 800-tick line; vsync low for 2 lines per 525-line frame (420000 ticks).
- frame_start asserted on the clk in which the tick with hc=0, vc=0 occurs.

## Configuration

- SCALE2X_EN: defined -> image pixel-doubled: DW=2*IMG_W, DH=2*IMG_H (350x350, X0=145, Y0=65); col increments every second in_img tick; row_base advances only after every second image line, so each source line is fetched twice. Undefined -> 1:1 display as above. Timing and ports identical in both builds.

## Test plan

- Reset, then run 2 lines: hsync first falls on output at tick hc=657 (1-tick delay), low 96 ticks, period 800 ticks = 1600 clks.
- Run 1 full frame: vsync low exactly 2 lines, period 525 lines; frame_start one pulse per 840000 clks.
- decrypt_done=0, RAM model data=8'hFF: red/green/blue all zero for entire frame; syncs normal.
- decrypt_done=1 before frame start, RAM returns addr[7:0]: line 152 first visible image pixel at hc=232 shows 8'h00; addresses 0..174 on that line; last image pixel (line 326, hc=406) read_addr=30624; border pixels zero.
- decrypt_done rises at vc=200: remainder of current frame black; following frame shows image.
- SCALE2X_EN build: read_addr sequence on line 65 = 0,0,1,1,...,174,174; line 66 repeats it; line 67 starts at 175; final read_addr 30624 at line 414.

Source files
------------

// File: rtl/vga_image_display.sv
// vga_image_display: 640x480@60 Hz VGA timing generator that shows a centred
// IMG_W x IMG_H RGB332 image read from an external frame buffer. The picture
// is blanked until decrypt_done, and that level is only sampled at frame start.
// Build option: define SCALE2X_EN to pixel-double the image (2x2 per source
// pixel); leaving it undefined gives a 1:1 display. Ports and timing are the
// same in both builds.
module vga_image_display #(
  parameter int CLK_DIV = 2,
  parameter int IMG_W   = 175,
  parameter int IMG_H   = 175
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        decrypt_done,
  input  logic [7:0]  pixel_data,
  output logic [14:0] read_addr,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frame_start
);

`ifdef SCALE2X_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  localparam int DW = SCALE * IMG_W;
  localparam int DH = SCALE * IMG_H;

  // Image window on screen, centred with integer floor
  localparam logic [9:0] X0    = 10'((640 - DW) / 2);
  localparam logic [9:0] X_END = 10'((640 - DW) / 2 + DW);
  localparam logic [9:0] Y0    = 10'((480 - DH) / 2);
  localparam logic [9:0] Y_END = 10'((480 - DH) / 2 + DH);

  // Raster timing
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] HS_START = 10'd656;
  localparam logic [9:0] HS_END   = 10'd751;
  localparam logic [9:0] V_MAX    = 10'd524;
  localparam logic [9:0] VS_START = 10'd490;
  localparam logic [9:0] VS_END   = 10'd491;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_reg;
  logic             tick;
  logic [9:0]       hc_reg, vc_reg;
  logic [9:0]       hc_next, vc_next;
  logic             in_cur, in_next;
  logic             line_start_next, frame_start_next, line_end_next;
  logic [9:0]       col_reg, col_cur;
  logic             col_phase_reg, col_phase_cur;
  logic [14:0]      row_base_reg, row_base_cur;
  logic             row_phase_reg, row_phase_cur;
  logic             col_adv, row_adv;
  logic             show_img_reg, show_cur;

  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (h >= X0) && (h < X_END) && (v >= Y0) && (v < Y_END);
  endfunction

  assign tick = (div_reg == DIV_W'(CLK_DIV - 1));

  // Next raster position, used to fetch the pixel one tick ahead of display
  always_comb begin
    hc_next = hc_reg;
    vc_next = vc_reg;
    if (hc_reg == H_MAX) begin
      hc_next = '0;
      vc_next = (vc_reg == V_MAX) ? 10'd0 : vc_reg + 10'd1;
    end else begin
      hc_next = hc_reg + 10'd1;
    end
  end

  assign in_cur           = in_window(hc_reg, vc_reg);
  assign in_next          = in_window(hc_next, vc_next);
  assign line_start_next  = (hc_next == 10'd0);
  assign frame_start_next = line_start_next && (vc_next == 10'd0);
  assign line_end_next    = in_next && (hc_next == X_END - 10'd1);

  // Address state as seen by the upcoming position (cleared at line/frame start)
  assign col_cur       = line_start_next  ? 10'd0 : col_reg;
  assign col_phase_cur = line_start_next  ? 1'b0  : col_phase_reg;
  assign row_base_cur  = frame_start_next ? 15'd0 : row_base_reg;
  assign row_phase_cur = frame_start_next ? 1'b0  : row_phase_reg;

  // With pixel doubling, only every second pixel/line steps the source address
  assign col_adv = (SCALE == 1) || col_phase_cur;
  assign row_adv = (SCALE == 1) || row_phase_cur;

  assign frame_start = tick && (hc_reg == 10'd0) && (vc_reg == 10'd0);
  assign show_cur    = frame_start ? decrypt_done : show_img_reg;

  // Pixel-tick divider and raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= '0;
      hc_reg  <= '0;
      vc_reg  <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + DIV_W'(1);
      if (tick) begin
        hc_reg <= hc_next;
        vc_reg <= vc_next;
      end
    end
  end

  // Incremental frame-buffer address generation (no multiplier)
  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg       <= '0;
      col_phase_reg <= 1'b0;
      row_base_reg  <= '0;
      row_phase_reg <= 1'b0;
      read_addr     <= '0;
    end else if (tick) begin
      col_reg       <= col_cur;
      col_phase_reg <= col_phase_cur;
      row_base_reg  <= row_base_cur;
      row_phase_reg <= row_phase_cur;
      if (in_next) begin
        read_addr     <= row_base_cur + {5'd0, col_cur};
        col_phase_reg <= ~col_phase_cur;
        if (col_adv) begin
          col_reg <= col_cur + 10'd1;
        end
        if (line_end_next) begin
          row_phase_reg <= ~row_phase_cur;
          if (row_adv) begin
            row_base_reg <= row_base_cur + 15'(IMG_W);
          end
        end
      end
    end
  end

  // Frame-level display enable, latched from decrypt_done at frame start only
  always_ff @(posedge clk) begin
    if (reset) begin
      show_img_reg <= 1'b0;
    end else if (frame_start) begin
      show_img_reg <= decrypt_done;
    end
  end

  // Output stage: syncs and colour for the position that was just fetched
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (tick) begin
      hsync <= !((hc_reg >= HS_START) && (hc_reg <= HS_END));
      vsync <= !((vc_reg >= VS_START) && (vc_reg <= VS_END));
      {red, green, blue} <= (in_cur && show_cur) ? pixel_data : 8'h00;
    end
  end

endmodule
